// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response, word RAM and peripheral bus signals of the memory/IO bus controller.
// The controller takes the slave modport; the CPU FSM, RAM and peripherals together take the master modport.
interface mio_bus_ctrl_if #(
  parameter int RAM_AW = 10
);
  // Handshake: a request (CPU_MIO & (MemRead | MemWrite)) is the "valid" side and must stay stable
  // until MIO_ready ("ready") is seen high for its single cycle; MIO_ready is never held for two cycles.
  logic              MemRead;
  logic              MemWrite;
  logic              CPU_MIO;
  logic [31:0]       Addr_out;
  logic [31:0]       Data_out;
  logic [31:0]       Data_in;
  logic              MIO_ready;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              io_rd;
  logic              io_wr;
  logic [31:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              io_ready;
  logic              busy;
  logic              bus_err;

  modport slave (
    input  MemRead, MemWrite, CPU_MIO, Addr_out, Data_out, ram_dout, io_rdata, io_ready,
    output Data_in, MIO_ready, ram_en, ram_we, ram_addr, ram_din, io_rd, io_wr, io_addr,
           io_wdata, busy, bus_err
  );

  modport master (
    output MemRead, MemWrite, CPU_MIO, Addr_out, Data_out, ram_dout, io_rdata, io_ready,
    input  Data_in, MIO_ready, ram_en, ram_we, ram_addr, ram_din, io_rd, io_wr, io_addr,
           io_wdata, busy, bus_err
  );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU requests to the word RAM or the IO bus, inserts the
// wait states each target needs, returns read data and pulses MIO_ready once per access.
module mio_bus_ctrl #(
  parameter int         RAM_AW      = 10,
  parameter int         RAM_LATENCY = 2,
  parameter int         IO_TIMEOUT  = 16,
  parameter logic [3:0] IO_BASE     = 4'hE
) (
  input  logic          clk,
  input  logic          reset_n,
  mio_bus_ctrl_if.slave bus,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAM_ACC  = 3'd1,
    S_RAM_WAIT = 3'd2,
    S_IO_ACC   = 3'd3,
    S_IO_WAIT  = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  // RAM_WAIT lasts RAM_LATENCY+1 cycles so ram_dout is sampled a cycle after it turns valid.
  localparam logic [7:0]  LP_RAM_LOAD = 8'(RAM_LATENCY);
  localparam logic [7:0]  LP_IO_LAST  = 8'(IO_TIMEOUT - 1);
  localparam logic [31:0] LP_TMO_DATA = 32'hDEADBEEF;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [7:0]  r_cnt;
  logic [31:0] r_data_in;
  logic        r_bus_err;

  logic w_req;
  logic w_io_sel;
  logic w_ram_done;
  logic w_io_tmo;

  assign w_req      = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
  assign w_io_sel   = (bus.Addr_out[31:28] >= IO_BASE);
  assign w_ram_done = (r_cnt == 8'd0);
  assign w_io_tmo   = (r_cnt == LP_IO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_req) w_next = w_io_sel ? S_IO_ACC : S_RAM_ACC;
      S_RAM_ACC:  w_next = S_RAM_WAIT;
      S_RAM_WAIT: begin
        if (!w_req)          w_next = S_IDLE;
        else if (w_ram_done) w_next = S_RESP;
      end
      S_IO_ACC:   w_next = S_IO_WAIT;
      S_IO_WAIT:  begin
        if (!w_req)                     w_next = S_IDLE;
        else if (bus.io_ready || w_io_tmo) w_next = S_RESP;
      end
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_data_in <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= bus.Addr_out;
            r_wdata <= bus.Data_out;
            r_we    <= bus.MemWrite;
            // A simultaneous read and write is carried out as a write but flagged.
            if (bus.MemRead && bus.MemWrite) r_bus_err <= 1'b1;
          end
        end
        S_RAM_ACC: r_cnt <= LP_RAM_LOAD;
        S_RAM_WAIT: begin
          if (w_req) begin
            if (w_ram_done) begin
              if (!r_we) r_data_in <= bus.ram_dout;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        S_IO_ACC: r_cnt <= '0;
        S_IO_WAIT: begin
          if (w_req) begin
            if (bus.io_ready) begin
              if (!r_we) r_data_in <= bus.io_rdata;
            end else if (w_io_tmo) begin
              if (!r_we) r_data_in <= LP_TMO_DATA;
              r_bus_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.MIO_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.io_rd     = 1'b0;
    bus.io_wr     = 1'b0;
    case (r_state)
      S_IDLE:    bus.busy      = 1'b0;
      S_RAM_ACC: begin
        bus.ram_en = 1'b1;
        bus.ram_we = r_we;
      end
      S_IO_ACC:  begin
        bus.io_rd = ~r_we;
        bus.io_wr = r_we;
      end
      S_RESP:    bus.MIO_ready = 1'b1;
      default: ;
    endcase
  end

  assign bus.ram_addr = r_addr[RAM_AW+1:2];
  assign bus.ram_din  = r_wdata;
  assign bus.io_addr  = r_addr;
  assign bus.io_wdata = r_wdata;
  assign bus.Data_in  = r_data_in;
  assign bus.bus_err  = r_bus_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: directed vector table, reset/abort sequences and random traffic
// against a transaction-level reference model, with behavioural RAM and peripheral models.
module tb_mio_bus_ctrl;

  localparam int RL = 2;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [31:0] wdata;
    int          io_dly;
    logic [31:0] io_val;
    bit          b2b;
    bit          keep;
    int          e_cyc;
    logic [31:0] e_data;
    bit          e_err;
    int          e_ram_en;
    int          e_ram_we;
    int          e_io_rd;
    int          e_io_wr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] dbg_state;

  mio_bus_ctrl_if #(.RAM_AW(10)) bus ();

  mio_bus_ctrl #(
    .RAM_AW(10), .RAM_LATENCY(RL), .IO_TIMEOUT(TO), .IO_BASE(4'hE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- environment models ----------------
  logic [31:0] ram_mem[1024];
  bit          ram_vld[1024];
  bit          rd_pend;
  int          rd_wait;
  logic [9:0]  rd_idx;
  int          io_dly_cfg;
  logic [31:0] io_val_cfg;
  bit          io_pend;
  int          io_wait;
  logic [31:0] io_cap_addr;
  logic [31:0] io_cap_wdata;
  int          n_ram_en = 0, n_ram_we = 0, n_io_rd = 0, n_io_wr = 0, n_mio = 0, n_excl = 0;

  function automatic logic [31:0] pat(input int idx);
    return 32'hA5000000 ^ (32'(idx) * 32'h00010101);
  endfunction

  always @(posedge clk) begin
    if (rd_pend) begin
      if (rd_wait <= 1) begin
        bus.ram_dout <= ram_vld[rd_idx] ? ram_mem[rd_idx] : pat(int'(rd_idx));
        rd_pend      <= 1'b0;
      end else begin
        rd_wait <= rd_wait - 1;
      end
    end
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram_mem[bus.ram_addr] <= bus.ram_din;
        ram_vld[bus.ram_addr] <= 1'b1;
      end else if (RL == 1) begin
        bus.ram_dout <= ram_vld[bus.ram_addr] ? ram_mem[bus.ram_addr] : pat(int'(bus.ram_addr));
      end else begin
        bus.ram_dout <= 32'hBAD0BAD0;
        rd_idx       <= bus.ram_addr;
        rd_pend      <= 1'b1;
        rd_wait      <= RL - 1;
      end
    end
  end

  always @(posedge clk) begin
    bus.io_ready <= 1'b0;
    bus.io_rdata <= 32'hFFFFFFFF;
    if (io_pend) begin
      if (io_wait == 1) begin
        bus.io_ready <= 1'b1;
        bus.io_rdata <= io_val_cfg;
        io_pend      <= 1'b0;
      end else begin
        io_wait <= io_wait - 1;
      end
    end
    if (bus.io_rd || bus.io_wr) begin
      io_cap_addr  <= bus.io_addr;
      io_cap_wdata <= bus.io_wdata;
      if (io_dly_cfg > 0) begin
        io_pend <= 1'b1;
        io_wait <= io_dly_cfg;
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      n_ram_en <= n_ram_en + int'(bus.ram_en);
      n_ram_we <= n_ram_we + int'(bus.ram_en & bus.ram_we);
      n_io_rd  <= n_io_rd + int'(bus.io_rd);
      n_io_wr  <= n_io_wr + int'(bus.io_wr);
      n_mio    <= n_mio + int'(bus.MIO_ready);
      if ((int'(bus.ram_en) + int'(bus.io_rd) + int'(bus.io_wr)) > 1) n_excl <= n_excl + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem[1024];
  bit          ref_vld[1024];
  logic [31:0] ref_data;
  bit          ref_err;

  function automatic vec_t ref_predict(input vec_t v);
    vec_t r;
    int   lat;
    int   idx;
    bit   is_io;
    r     = v;
    idx   = int'(v.addr[11:2]);
    is_io = (v.addr[31:28] >= 4'hE);
    if (v.rd && v.wr) ref_err = 1'b1;
    r.e_ram_en = is_io ? 0 : 1;
    r.e_ram_we = (!is_io && v.wr) ? 1 : 0;
    r.e_io_rd  = (is_io && !v.wr) ? 1 : 0;
    r.e_io_wr  = (is_io && v.wr) ? 1 : 0;
    if (!is_io) begin
      lat = RL + 2;
      if (v.wr) begin
        ref_mem[idx] = v.wdata;
        ref_vld[idx] = 1'b1;
      end else begin
        ref_data = ref_vld[idx] ? ref_mem[idx] : pat(idx);
      end
    end else if (v.io_dly == 0 || v.io_dly >= TO) begin
      lat     = TO + 1;
      ref_err = 1'b1;
      if (!v.wr) ref_data = 32'hDEADBEEF;
    end else begin
      lat = v.io_dly + 2;
      if (!v.wr) ref_data = v.io_val;
    end
    r.e_cyc  = lat + 1 + (v.b2b ? 1 : 0);
    r.e_data = ref_data;
    r.e_err  = ref_err;
    return r;
  endfunction

  // ---------------- scoreboard / driver ----------------
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] act=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic drop_req();
    bus.CPU_MIO  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s_en, s_we, s_rd, s_wr, cyc;
    bit got;
    if (!v.b2b) @(negedge clk);
    io_dly_cfg   = v.io_dly;
    io_val_cfg   = v.io_val;
    bus.CPU_MIO  = 1'b1;
    bus.MemRead  = v.rd;
    bus.MemWrite = v.wr;
    bus.Addr_out = v.addr;
    bus.Data_out = v.wdata;
    s_en = n_ram_en; s_we = n_ram_we; s_rd = n_io_rd; s_wr = n_io_wr;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.MIO_ready) got = 1'b1;
    end
    chk("latency", idx, cyc, v.e_cyc);
    chk("data_in", idx, bus.Data_in, v.e_data);
    chk("bus_err", idx, 32'(bus.bus_err), 32'(v.e_err));
    chk("ram_en_cnt", idx, n_ram_en - s_en, v.e_ram_en);
    chk("ram_we_cnt", idx, n_ram_we - s_we, v.e_ram_we);
    chk("io_rd_cnt", idx, n_io_rd - s_rd, v.e_io_rd);
    chk("io_wr_cnt", idx, n_io_wr - s_wr, v.e_io_wr);
    if ((v.e_io_rd + v.e_io_wr) > 0) chk("io_addr", idx, io_cap_addr, v.addr);
    if (v.e_io_wr > 0) chk("io_wdata", idx, io_cap_wdata, v.wdata);
    if (!v.keep) drop_req();
  endtask

  vec_t vecs[11];

  initial begin
    vec_t v;
    logic [31:0] rnd;
    int s_mio, sel;
    bit prev_keep;

    vecs[0]  = '{32'h0000_0010, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 5, 32'h0000_0000, 0, 1, 1, 0, 0};
    vecs[1]  = '{32'h0000_0010, 1, 0, 32'h0,         0, 0, 0, 0, 5, 32'h1234_5678, 0, 1, 0, 0, 0};
    vecs[2]  = '{32'h0000_0020, 0, 1, 32'hCAFE_F00D, 0, 0, 0, 1, 5, 32'h1234_5678, 0, 1, 1, 0, 0};
    vecs[3]  = '{32'h0000_0020, 1, 0, 32'h0,         0, 0, 1, 0, 6, 32'hCAFE_F00D, 0, 1, 0, 0, 0};
    vecs[4]  = '{32'hE000_0000, 1, 0, 32'h0,         3, 32'hA5, 0, 0, 6, 32'h0000_00A5, 0, 0, 0, 1, 0};
    vecs[5]  = '{32'h0000_0013, 1, 0, 32'h0,         0, 0, 0, 0, 5, 32'h1234_5678, 0, 1, 0, 0, 0};
    vecs[6]  = '{32'hE000_0100, 0, 1, 32'h55,        1, 0, 0, 0, 4, 32'h1234_5678, 0, 0, 0, 0, 1};
    vecs[7]  = '{32'h0000_0030, 1, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 5, 32'h1234_5678, 1, 1, 1, 0, 0};
    vecs[8]  = '{32'h0000_0030, 1, 0, 32'h0,         0, 0, 0, 0, 5, 32'h0BAD_F00D, 1, 1, 0, 0, 0};
    vecs[9]  = '{32'hF000_0004, 1, 0, 32'h0,         0, 0, 0, 0, 18, 32'hDEAD_BEEF, 1, 0, 0, 1, 0};
    vecs[10] = '{32'h0000_0020, 1, 0, 32'h0,         0, 0, 0, 0, 5, 32'hCAFE_F00D, 1, 1, 0, 0, 0};

    drop_req();
    bus.Addr_out = '0;
    bus.Data_out = '0;
    io_dly_cfg   = 0;
    io_val_cfg   = '0;
    ref_data     = '0;
    ref_err      = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_ones", 0, $countones({bus.Data_in, bus.MIO_ready, bus.ram_en, bus.ram_we,
        bus.ram_addr, bus.ram_din, bus.io_rd, bus.io_wr, bus.io_addr, bus.io_wdata, bus.busy,
        bus.bus_err}), 0);
    chk("reset_state", 0, 32'(dbg_state), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 0, 32'(bus.busy), 0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      v = ref_predict(vecs[i]);
      run_vec(vecs[i], i);
    end

    // reset asserted in the middle of RAM_WAIT
    @(negedge clk);
    bus.CPU_MIO = 1'b1; bus.MemRead = 1'b1; bus.Addr_out = 32'h10;
    s_mio = n_mio;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_outputs_ones", 0, $countones({bus.Data_in, bus.MIO_ready, bus.ram_en, bus.ram_we,
        bus.ram_addr, bus.ram_din, bus.io_rd, bus.io_wr, bus.io_addr, bus.io_wdata, bus.busy,
        bus.bus_err}), 0);
    chk("midrst_state", 0, 32'(dbg_state), 0);
    drop_req();
    @(negedge clk);
    reset_n  = 1'b1;
    ref_data = '0;
    ref_err  = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_busy", 0, 32'(bus.busy), 0);
    chk("postrst_mio", 0, n_mio - s_mio, 0);

    // abort: drop MemRead while in RAM_WAIT
    bus.CPU_MIO = 1'b1; bus.MemRead = 1'b1; bus.Addr_out = 32'h20;
    s_mio = n_mio;
    repeat (2) @(negedge clk);
    bus.MemRead = 1'b0;
    @(negedge clk);
    chk("abort_busy", 0, 32'(bus.busy), 0);
    chk("abort_state", 0, 32'(dbg_state), 0);
    repeat (6) @(negedge clk);
    chk("abort_mio", 0, n_mio - s_mio, 0);
    chk("abort_data", 0, bus.Data_in, ref_data);
    drop_req();

    // random traffic against the reference model
    prev_keep = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rnd = $urandom();
      sel = $urandom_range(0, 9);
      v.b2b = prev_keep;
      if ($urandom_range(0, 2) == 0) v.addr = {4'($urandom_range(14, 15)), rnd[27:0]};
      else                           v.addr = {4'($urandom_range(0, 13)), rnd[27:0]};
      v.rd     = (sel == 0) || (sel > 4);
      v.wr     = (sel <= 4);
      v.wdata  = $urandom();
      v.io_val = $urandom();
      v.io_dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO - 2);
      v.keep   = (i < 59) && ($urandom_range(0, 2) == 0);
      prev_keep = v.keep;
      v = ref_predict(v);
      run_vec(v, 100 + i);
    end

    @(negedge clk);
    chk("mio_single_pulse", 0, 32'(bus.MIO_ready), 0);
    chk("strobe_exclusive", 0, n_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
